// File: rtl/game_pkg.sv
// Shared game-flow constants: screen-mode encodings, charge limit and BCD score
// ceiling. The display path decodes the same mode values.
package game_pkg;

  typedef enum logic [2:0] {
    MODE_TITLE = 3'b000,
    MODE_GAME  = 3'b001,
    MODE_INBET = 3'b010,
    MODE_WIN   = 3'b011,
    MODE_GOVER = 3'b100
  } mode_t;

  localparam logic [2:0]  MAX_CHARGE = 3'd5;
  localparam logic [11:0] BCD_MAX    = 12'h999;

  // Larger of two integers; used to size the shared frame-count timers.
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/game_mode_ctrl_if.sv
// Signal bundle between the game-flow controller and its surroundings: frame
// sync, player buttons and gameplay events in, display/bookkeeping state out.
interface game_mode_ctrl_if;

  logic        vsync;
  logic        start_btn;
  logic        fire_btn;
  logic        kill_evt;
  logic        hit_evt;
  logic [2:0]  mode;
  logic [2:0]  level;
  logic [11:0] score;
  logic [2:0]  charge_count;
  logic [1:0]  lives;
  logic        shot_fire;

  // Driving side: sync generator, buttons and collision logic.
  modport master (
    output vsync, start_btn, fire_btn, kill_evt, hit_evt,
    input  mode, level, score, charge_count, lives, shot_fire
  );

  // Controller side.
  modport slave (
    input  vsync, start_btn, fire_btn, kill_evt, hit_evt,
    output mode, level, score, charge_count, lives, shot_fire
  );

endinterface

// File: rtl/game_mode_ctrl_bcd3_incr.sv
// Three-digit BCD incrementer. Carries digit to digit and sticks at 999,
// raising sat when the input is already at the ceiling.
module bcd3_incr
  import game_pkg::*;
(
  input  logic [11:0] bcd_in,
  output logic [11:0] bcd_out,
  output logic        sat
);

  logic [3:0] d0, d1, d2;

  assign d0  = bcd_in[3:0];
  assign d1  = bcd_in[7:4];
  assign d2  = bcd_in[11:8];
  assign sat = (bcd_in == BCD_MAX);

  // Ripple the +1 through the digits, wrapping a 9 to 0 and carrying on.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    bcd_out = bcd_in;
    if (!sat) begin
      if (d0 != 4'd9) begin
        bcd_out[3:0] = d0 + 4'd1;
      end else begin
        bcd_out[3:0] = 4'd0;
        if (d1 != 4'd9) begin
          bcd_out[7:4] = d1 + 4'd1;
        end else begin
          bcd_out[7:4]  = 4'd0;
          bcd_out[11:8] = d2 + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/game_mode_ctrl.sv
// Game-flow controller: sequences title, play, between-level, win and
// game-over screens and keeps level, lives, BCD score and shot charge. All
// frame timing advances on the vsync falling-edge tick.
module game_mode_ctrl
  import game_pkg::*;
#(
  parameter int MAX_LEVEL       = 5,
  parameter int KILLS_PER_LEVEL = 8,
  parameter int LIVES           = 3,
  parameter int INBET_FRAMES    = 120,
  parameter int END_FRAMES      = 180,
  parameter int CHARGE_FRAMES   = 30,
  parameter int INVULN_FRAMES   = 60
) (
  input logic            clk,
  input logic            rst_n,
  game_mode_ctrl_if.slave bus
);

  localparam int TW = $clog2(max2(max2(INBET_FRAMES, END_FRAMES),
                                  max2(CHARGE_FRAMES, INVULN_FRAMES))) + 1;
  localparam int KW = $clog2(KILLS_PER_LEVEL) + 1;

  mode_t          state_q, state_d;
  logic [2:0]     level_q, level_d;
  logic [11:0]    score_q, score_d;
  logic [KW-1:0]  kills_q, kills_d;
  logic [2:0]     charge_q, charge_d;
  logic [TW-1:0]  ctmr_q, ctmr_d;
  logic [TW-1:0]  inv_q, inv_d;
  logic [TW-1:0]  frame_q, frame_d;
  logic [1:0]     lives_q, lives_d;
  logic           shot_q, shot_d;

  logic           vs_q, start_q, fire_q;
  logic           tick, start_edge, fire_edge;
  logic           refill, fire_ok, fatal, cleared;
  logic [11:0]    score_inc;
  logic           score_sat;

  assign tick       = vs_q & ~bus.vsync;
  assign start_edge = bus.start_btn & ~start_q;
  assign fire_edge  = bus.fire_btn & ~fire_q;

  bcd3_incr u_score_incr (
    .bcd_in  (score_q),
    .bcd_out (score_inc),
    .sat     (score_sat)
  );

  // Delayed copies of vsync and the buttons for edge detection.
  always_ff @(posedge clk) begin
    // NOTE: the reset is sampled on the clock edge here, so it takes effect
    // only at the next rising edge and wins over every event in that cycle.
    if (!rst_n) begin
      vs_q    <= 1'b0;
      start_q <= 1'b0;
      fire_q  <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so all flops update
      // together from the values present before the edge.
      vs_q    <= bus.vsync;
      start_q <= bus.start_btn;
      fire_q  <= bus.fire_btn;
    end
  end

  // State and bookkeeping registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= MODE_TITLE;
      level_q  <= '0;
      score_q  <= '0;
      kills_q  <= '0;
      charge_q <= '0;
      ctmr_q   <= '0;
      inv_q    <= '0;
      frame_q  <= '0;
      lives_q  <= '0;
      shot_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      score_q  <= score_d;
      kills_q  <= kills_d;
      charge_q <= charge_d;
      ctmr_q   <= ctmr_d;
      inv_q    <= inv_d;
      frame_q  <= frame_d;
      lives_q  <= lives_d;
      shot_q   <= shot_d;
    end
  end

  // Next-state and bookkeeping: screen sequencing, score, lives, charge, fire.
  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    score_d  = score_q;
    kills_d  = kills_q;
    charge_d = charge_q;
    ctmr_d   = ctmr_q;
    inv_d    = inv_q;
    frame_d  = frame_q;
    lives_d  = lives_q;
    shot_d   = 1'b0;
    refill   = 1'b0;
    fire_ok  = 1'b0;
    fatal    = 1'b0;
    cleared  = 1'b0;

    unique case (state_q)
      MODE_TITLE: begin
        if (start_edge) begin
          state_d  = MODE_GAME;
          level_d  = 3'd1;
          score_d  = '0;
          kills_d  = '0;
          charge_d = '0;
          ctmr_d   = '0;
          inv_d    = '0;
          frame_d  = '0;
          lives_d  = 2'(LIVES);
        end
      end

      MODE_GAME: begin
        // Charge refill: the timer idles at 0 while the magazine is full.
        if (charge_q == MAX_CHARGE) begin
          ctmr_d = '0;
        end else if (tick) begin
          if (ctmr_q == TW'(CHARGE_FRAMES - 1)) begin
            ctmr_d = '0;
            refill = 1'b1;
          end else begin
            ctmr_d = ctmr_q + TW'(1);
          end
        end

        fire_ok = fire_edge && (charge_q != 3'd0);
        shot_d  = fire_ok;
        if (refill && !fire_ok) begin
          charge_d = charge_q + 3'd1;
        end else if (!refill && fire_ok) begin
          charge_d = charge_q - 3'd1;
        end

        // Invulnerability window: hits only land while the timer is idle.
        if (tick && inv_q != '0) begin
          inv_d = inv_q - TW'(1);
        end
        if (bus.hit_evt && inv_q == '0) begin
          lives_d = lives_q - 2'd1;
          inv_d   = TW'(INVULN_FRAMES);
          fatal   = (lives_q == 2'd1);
        end

        if (bus.kill_evt) begin
          if (!score_sat) begin
            score_d = score_inc;
          end
          kills_d = kills_q + KW'(1);
          cleared = (kills_q == KW'(KILLS_PER_LEVEL - 1));
        end

        // A fatal hit outranks a level clear landing in the same cycle.
        if (fatal) begin
          state_d = MODE_GOVER;
          frame_d = '0;
        end else if (cleared) begin
          state_d = (level_q == 3'(MAX_LEVEL)) ? MODE_WIN : MODE_INBET;
          frame_d = '0;
        end
      end

      MODE_INBET: begin
        if (tick) begin
          frame_d = frame_q + TW'(1);
        end
        if (start_edge || (tick && frame_q == TW'(INBET_FRAMES - 1))) begin
          state_d  = MODE_GAME;
          level_d  = level_q + 3'd1;
          kills_d  = '0;
          charge_d = '0;
          ctmr_d   = '0;
          inv_d    = '0;
          frame_d  = '0;
        end
      end

      MODE_WIN, MODE_GOVER: begin
        if (tick) begin
          frame_d = frame_q + TW'(1);
        end
        if (start_edge || (tick && frame_q == TW'(END_FRAMES - 1))) begin
          state_d = MODE_TITLE;
          level_d = '0;
          frame_d = '0;
        end
      end

      default: begin
        state_d = MODE_TITLE;
      end
    endcase
  end

  assign bus.mode         = state_q;
  assign bus.level        = level_q;
  assign bus.score        = score_q;
  assign bus.charge_count = charge_q;
  assign bus.lives        = lives_q;
  assign bus.shot_fire    = shot_q;

endmodule
